lab8_sysid_checker: RTL and testbench

Avalon-MM read master that sits at the other end of the system-ID slave interface. On a start pulse it reads the ID word (address 0) and the timestamp word (address 1), compares each against a build-time expected value, and reports pass/fail with an error code. Software and board bring-up logic use it to confirm that the loaded FPGA image matches the software build.

---
 rtl/lab8_sysid_pkg.sv | 26 ++
 rtl/lab8_timeout_counter.sv | 30 +++
 rtl/lab8_sysid_checker.sv | 140 ++++++++++++++
 tb/tb_lab8_sysid_checker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab8_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
//   state_t  : checker FSM states
//   err_t    : result code reported on error_code
//   ADDR_ID / ADDR_TS : word addresses on the system-ID slave
package lab8_sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      WAIT_ID,
      REQ_TS,
      WAIT_TS,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_ID      = 2'd1,
      ERR_TS      = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_t;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/lab8_timeout_counter.sv
// Per-transaction watchdog for the system-ID checker.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count (has priority over enable)
//   enable       : count this cycle
//   expired      : this enabled cycle is the LIMIT-th since the last clear
module lab8_timeout_counter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WIDTH-1:0] count;

   // Flagged one cycle early so the owner's next state lands exactly
   // LIMIT cycles after the clear.
   assign expired = enable && (count >= WIDTH'(LIMIT - 1));

   always_ff @(posedge clock) begin
      if (reset || clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/lab8_sysid_checker.sv
// Avalon-MM read master that checks the system-ID slave against build-time
// values: reads address 0 (ID) then address 1 (timestamp), one read at a time.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : one-cycle request, ignored while busy
//   avm_*               : Avalon-MM read master port
//   busy / done         : check in progress / one-cycle completion pulse
//   pass / error_code   : result of the last completed check
//   id_value / timestamp_value : words captured from the slave
import lab8_sysid_pkg::*;

module lab8_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1508702477,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [1:0]  error_code,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value
);

   state_t state;
   err_t   ts_code;
   logic   accepted;
   logic   tmo_clear;
   logic   tmo_enable;
   logic   tmo_expired;

   assign accepted   = avm_read & ~avm_waitrequest;
   assign tmo_enable = (state == REQ_ID) || (state == WAIT_ID) ||
                       (state == REQ_TS) || (state == WAIT_TS);
   // Cleared whenever a REQ state is about to be entered: from IDLE/FINISH
   // for the ID read, and on the ID data beat for the timestamp read.
   assign tmo_clear  = (state == IDLE) || (state == FINISH) ||
                       ((state == WAIT_ID) && avm_readdatavalid);

   lab8_timeout_counter #(
      .WIDTH (16),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expired (tmo_expired)
   );

   // Result as seen on the timestamp data beat; the ID was captured earlier
   // and a mismatch there outranks the timestamp.
   always_comb begin
      ts_code = ERR_NONE;
      if (id_value != EXPECTED_ID)
         ts_code = ERR_ID;
      else if (avm_readdata != EXPECTED_TIMESTAMP)
         ts_code = ERR_TS;
   end

   // A handshake or data beat on the same cycle as expiry still wins:
   // the transaction completed inside its budget.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         avm_read        <= 1'b0;
         avm_address     <= ADDR_ID;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         error_code      <= ERR_NONE;
         id_value        <= '0;
         timestamp_value <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= REQ_ID;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_ID;
                  busy        <= 1'b1;
               end
            end
            REQ_ID, REQ_TS: begin
               if (accepted) begin
                  avm_read <= 1'b0;
                  state    <= (state == REQ_ID) ? WAIT_ID : WAIT_TS;
               end else if (tmo_expired) begin
                  avm_read   <= 1'b0;
                  state      <= FINISH;
                  done       <= 1'b1;
                  pass       <= 1'b0;
                  error_code <= ERR_TIMEOUT;
               end
            end
            WAIT_ID: begin
               if (avm_readdatavalid) begin
                  id_value    <= avm_readdata;
                  state       <= REQ_TS;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_TS;
               end else if (tmo_expired) begin
                  state      <= FINISH;
                  done       <= 1'b1;
                  pass       <= 1'b0;
                  error_code <= ERR_TIMEOUT;
               end
            end
            WAIT_TS: begin
               if (avm_readdatavalid) begin
                  timestamp_value <= avm_readdata;
                  state           <= FINISH;
                  done            <= 1'b1;
                  pass            <= (ts_code == ERR_NONE);
                  error_code      <= ts_code;
               end else if (tmo_expired) begin
                  state      <= FINISH;
                  done       <= 1'b1;
                  pass       <= 1'b0;
                  error_code <= ERR_TIMEOUT;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lab8_sysid_checker.sv
// Scoreboard bench for lab8_sysid_checker: stimulus pushes the expected
// result of each check, a monitor pops it on every done pulse.
module tb_lab8_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1508702477;
   localparam int          TMO    = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic        busy, done, pass;
   logic [1:0]  error_code;
   logic [31:0] id_value, timestamp_value;

   lab8_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (TMO)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .busy              (busy),
      .done              (done),
      .pass              (pass),
      .error_code        (error_code),
      .id_value          (id_value),
      .timestamp_value   (timestamp_value)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   // ---------------- responder (slave model) ----------------
   logic [31:0] rsp_id = EXP_ID;
   logic [31:0] rsp_ts = EXP_TS;
   int          n_wait = 0;
   logic        stuck  = 1'b0;
   int          inj_req = 0;

   int   inj_ack = 0;
   int   stall_cnt = 0;
   int   saw_addr1 = 0;
   logic pending = 1'b0;
   logic pending_addr = 1'b0;
   logic prev_wait = 1'b0;
   logic prev_addr = 1'b0;

   always @(negedge clock) begin
      avm_readdatavalid = 1'b0;
      if (pending) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = pending_addr ? rsp_ts : rsp_id;
         pending           = 1'b0;
      end else if (inj_ack != inj_req) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = 32'hDEADBEEF;
         inj_ack           = inj_req;
      end
      // A stalled request must still be presented unchanged.
      if (prev_wait && !stuck && !reset) begin
         check("hold_read", 32'(avm_read), 32'd1);
         check("hold_addr", 32'(avm_address), 32'(prev_addr));
      end
      if (avm_read && !reset) begin
         if (avm_address) saw_addr1++;
         if (stuck || stall_cnt < n_wait) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
         end else begin
            avm_waitrequest = 1'b0;
            pending         = 1'b1;
            pending_addr    = avm_address;
         end
      end else begin
         avm_waitrequest = 1'b0;
         stall_cnt       = 0;
      end
      prev_wait = avm_waitrequest && avm_read;
      prev_addr = avm_address;
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int          at;
      logic        pass;
      logic [1:0]  err;
      logic [31:0] id;
      logic [31:0] ts;
   } exp_t;

   exp_t sb[$];
   int   n_done = 0;

   always @(negedge clock) begin
      if (!reset && done) begin
         n_done++;
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d required no pulse", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.at));
            check("pass", 32'(pass), 32'(e.pass));
            check("error_code", 32'(error_code), 32'(e.err));
            check("id_value", id_value, e.id);
            check("timestamp_value", timestamp_value, e.ts);
            check("busy_at_done", 32'(busy), 32'd1);
         end
      end
   end

   // Called at a negedge: that cycle is cycle 0, start is sampled at its end.
   task automatic run(input int off, input logic p, input logic [1:0] er,
                      input logic [31:0] i, input logic [31:0] t);
      exp_t e;
      e.at = cyc + off; e.pass = p; e.err = er; e.id = i; e.ts = t;
      sb.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int k = 0;
      while (sb.size() != 0 && k < lim) begin
         tick();
         k++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done within %0d cycles required a pulse", lim);
         sb.delete();
      end
      tick();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err"}, 32'(error_code), 32'd0);
      check({tag, "_id"}, id_value, 32'd0);
      check({tag, "_ts"}, timestamp_value, 32'd0);
      check({tag, "_read"}, 32'(avm_read), 32'd0);
      check({tag, "_addr"}, 32'(avm_address), 32'd0);
   endtask

   initial begin
      int s;
      int d0;
      tick(3);
      check_reset_vals("rst");
      reset = 1'b0;
      tick();

      // Nominal, zero wait states: done at cycle 5.
      run(5, 1'b1, 2'd0, EXP_ID, EXP_TS);
      check("busy_cycle1", 32'(busy), 32'd1);
      wait_done(40);
      check("busy_after", 32'(busy), 32'd0);

      // ID mismatch: timestamp still read.
      rsp_id = 32'h1;
      s = saw_addr1;
      run(5, 1'b0, 2'd1, 32'h1, EXP_TS);
      wait_done(40);
      check("ts_read_after_id_mismatch", 32'(saw_addr1 > s), 32'd1);
      rsp_id = EXP_ID;

      // Three wait states per request: done at cycle 11.
      n_wait = 3;
      run(11, 1'b1, 2'd0, EXP_ID, EXP_TS);
      wait_done(40);
      n_wait = 0;

      // Slave stuck: REQ_ID entered at cycle 1, abort at cycle 1+8.
      stuck = 1'b1;
      run(1 + TMO, 1'b0, 2'd3, EXP_ID, EXP_TS);
      wait_done(40);
      check("read_low_after_timeout", 32'(avm_read), 32'd0);
      tick(2);
      check("read_low_later", 32'(avm_read), 32'd0);
      stuck = 1'b0;
      tick();

      // Spurious data in IDLE, then a second start while busy.
      inj_req++;
      tick(2);
      check("spurious_id_ignored", id_value, EXP_ID);
      check("spurious_ts_ignored", timestamp_value, EXP_TS);
      d0 = n_done;
      run(5, 1'b1, 2'd0, EXP_ID, EXP_TS);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(40);
      tick(4);
      check("single_done", 32'(n_done - d0), 32'd1);

      // Reset during WAIT_TS (cycle 4), then a clean run.
      d0 = n_done;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(3);
      reset = 1'b1;
      tick();
      check_reset_vals("midrst");
      reset = 1'b0;
      tick(2);
      check("no_done_on_reset", 32'(n_done - d0), 32'd0);
      run(5, 1'b1, 2'd0, EXP_ID, EXP_TS);
      wait_done(40);
      check("done_after_reset", 32'(n_done - d0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion required $finish");
      $fatal(1, "watchdog");
   end

endmodule
